// File: rtl/ysyx_22040383_id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded ID instruction or injects an addi x0,x0,0 bubble.
// Define YSYX_22040383_PERF_CNT_EN to build the bubble/redirect/hold performance counters.
module ysyx_22040383_id_exe_reg #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              hold,
   input  logic              flush_exe_reg,
   input  logic              redirect_flush,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [31:0]       id_instr,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [XLEN-1:0]   id_rs1_data,
   input  logic [XLEN-1:0]   id_rs2_data,
   input  logic [4:0]        id_rd,
   input  logic              id_has_rd,
   input  logic [1:0]        id_forwarding_a_option,
   input  logic [1:0]        id_forwarding_b_option,
   output logic [XLEN-1:0]   exe_pc,
   output logic [XLEN-1:0]   exe_imm,
   output logic [XLEN-1:0]   exe_rs1_data,
   output logic [XLEN-1:0]   exe_rs2_data,
   output logic [31:0]       exe_instr,
   output logic [6:0]        exe_instr_opcode,
   output logic [4:0]        exe_rd,
   output logic              exe_has_rd,
   output logic [1:0]        exe_forwarding_a_option,
   output logic [1:0]        exe_forwarding_b_option,
   output logic              exe_valid,
   output logic              ex_is_flushed,
   output logic [CNT_W-1:0]  perf_bubble_cnt,
   output logic [CNT_W-1:0]  perf_redirect_cnt,
   output logic [CNT_W-1:0]  perf_hold_cnt
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic [XLEN-1:0] r_pc, r_imm, r_rs1_data, r_rs2_data;
   logic [31:0]     r_instr;
   logic [4:0]      r_rd;
   logic            r_has_rd;
   logic [1:0]      r_fwd_a, r_fwd_b;
   logic            r_valid;
   logic            r_flushed;
   logic            w_bubble;

   assign w_bubble = flush_exe_reg | redirect_flush | ~valid;

   // NOTE: hold is tested before the bubble so a stalled EXE keeps its instruction even
   // while hazard control or a redirect asks for a bubble; only rst overrides it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= '0;
         r_imm      <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_instr    <= NOP_INSTR;
         r_rd       <= '0;
         r_has_rd   <= 1'b0;
         r_fwd_a    <= 2'b00;
         r_fwd_b    <= 2'b00;
         r_valid    <= 1'b0;
         r_flushed  <= 1'b1;
      end else if (!hold) begin
         if (w_bubble) begin
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_instr    <= NOP_INSTR;
            r_rd       <= '0;
            r_has_rd   <= 1'b0;
            r_fwd_a    <= 2'b00;
            r_fwd_b    <= 2'b00;
            r_valid    <= 1'b0;
            r_flushed  <= 1'b1;
         end else begin
            r_pc       <= id_pc;
            r_imm      <= id_imm;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_instr    <= id_instr;
            r_rd       <= id_rd;
            r_has_rd   <= id_has_rd;
            r_fwd_a    <= id_forwarding_a_option;
            r_fwd_b    <= id_forwarding_b_option;
            r_valid    <= 1'b1;
            r_flushed  <= 1'b0;
         end
      end
   end

   assign exe_pc                  = r_pc;
   assign exe_imm                 = r_imm;
   assign exe_rs1_data            = r_rs1_data;
   assign exe_rs2_data            = r_rs2_data;
   assign exe_instr               = r_instr;
   assign exe_instr_opcode        = r_instr[6:0];
   assign exe_rd                  = r_rd;
   assign exe_has_rd              = r_has_rd;
   assign exe_forwarding_a_option = r_fwd_a;
   assign exe_forwarding_b_option = r_fwd_b;
   assign exe_valid               = r_valid;
   assign ex_is_flushed           = r_flushed;

`ifdef YSYX_22040383_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_bubble_cnt, r_redirect_cnt, r_hold_cnt;
   logic             w_bubble_inc, w_redirect_inc;

   // A combined redirect + load-use bubble is attributed to the redirect only.
   assign w_bubble_inc   = ~hold & flush_exe_reg & ~redirect_flush;
   assign w_redirect_inc = ~hold & redirect_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bubble_cnt   <= '0;
         r_redirect_cnt <= '0;
         r_hold_cnt     <= '0;
      end else begin
         if (w_bubble_inc && r_bubble_cnt != CNT_MAX)
            r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
         if (w_redirect_inc && r_redirect_cnt != CNT_MAX)
            r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
         if (hold && r_hold_cnt != CNT_MAX)
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
      end
   end

   assign perf_bubble_cnt   = r_bubble_cnt;
   assign perf_redirect_cnt = r_redirect_cnt;
   assign perf_hold_cnt     = r_hold_cnt;
`else
   assign perf_bubble_cnt   = '0;
   assign perf_redirect_cnt = '0;
   assign perf_hold_cnt     = '0;
`endif

endmodule

// File: doc/ysyx_22040383_id_exe_reg.md
# ysyx_22040383_id_exe_reg

ID/EXE pipeline register of the five-stage core, directly downstream of the hazard control unit. Each cycle it captures the decoded instruction, operands and per-operand forwarding selects from ID, or injects a bubble when hazard control asserts `flush_exe_reg` (load-use) or EXE resolves a redirect. Its outputs (`exe_rd`, `exe_has_rd`, `exe_instr_opcode`, `ex_is_flushed`) feed back into hazard control for the next ID instruction, so the reset and bubble values below are contractual.

## Interface
- `XLEN`, 64: datapath width for pc, operand and immediate fields.
- `CNT_W`, 32: width of the performance counters.

- `clk` in 1: core clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: ID holds a real instruction this cycle.
- `hold` in 1: downstream (MEM/EXE multi-cycle) stall; EXE register must keep its contents.
- `flush_exe_reg` in 1: load-use bubble request from hazard control.
- `redirect_flush` in 1: EXE resolved a taken branch/jump; the ID instruction is wrong-path.
- `id_pc` in XLEN; `id_instr` in 32; `id_imm` in XLEN.
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data.
- `id_rd` in 5; `id_has_rd` in 1.
- `id_forwarding_a_option`, `id_forwarding_b_option` in 2: 00 regfile, 01 EXE, 10 MEM, 11 WB.
- `exe_pc`, `exe_imm`, `exe_rs1_data`, `exe_rs2_data` out XLEN.
- `exe_instr` out 32; `exe_instr_opcode` out 7 (= `exe_instr[6:0]`).
- `exe_rd` out 5; `exe_has_rd` out 1.
- `exe_forwarding_a_option`, `exe_forwarding_b_option` out 2.
- `exe_valid` out 1; `ex_is_flushed` out 1 (EXE contents are a bubble).
- `perf_bubble_cnt`, `perf_redirect_cnt`, `perf_hold_cnt` out CNT_W.

## Operation
- One register stage; update priority per cycle: `rst` > `hold` > bubble > load.
- Bubble condition: `flush_exe_reg | redirect_flush | ~valid`.
- Bubble value: `exe_instr`=32'h0000_0013 (addi x0,x0,0), so opcode 7'b0010011 (never load type); `exe_rd`=0, `exe_has_rd`=0, forwarding options 00, `exe_valid`=0, `ex_is_flushed`=1. `exe_pc`, `exe_imm` and operand data are don't-care; the implementation drives 0.
- Load: every `id_*` field is copied to `exe_*`, with `exe_valid`=1 and `ex_is_flushed`=0.
- Hold: all `exe_*` and flag registers are unchanged, whatever the state of `flush_exe_reg` or `redirect_flush`. Hazard control re-evaluates on the held state next cycle, and ID is stalled upstream by the same `hold`.
- `flush_exe_reg` and `redirect_flush` together: one bubble. `perf_redirect_cnt` increments and `perf_bubble_cnt` does not.
- The block performs no forwarding arithmetic. Options pass through unchanged for the EXE operand muxes.

## Timing
- Latency: 1 cycle from ID inputs to `exe_*` outputs. No combinational path from input to output.
- Reset: all outputs take bubble values, with `exe_pc`=0. `rst` held mid-hold or mid-flush still forces the bubble on the next edge. Perf counters clear to 0.
- A load-use stall gives exactly one bubble per `flush_exe_reg` cycle not masked by `hold`.
- Counters saturate at all-ones with no wrap:
  - bubble: a bubble was loaded due to `flush_exe_reg` only.
  - redirect: a bubble was loaded with `redirect_flush` set.
  - hold: `hold` was high and `rst` was low.

## Configuration
- `YSYX_22040383_PERF_CNT_EN` defined: the three counters are implemented as above.
- Undefined: the counter registers are not built, and the `perf_*` ports remain but are tied to 0. Pipeline behaviour is identical either way.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `valid`=1 and random `id_*` -> `exe_has_rd`=0, `ex_is_flushed`=1, `exe_instr`=32'h13, counters 0.
- Load: `valid`=1, `id_instr`=32'h00A28293, `id_rd`=5, `id_has_rd`=1, fwd a=01 -> next cycle `exe_rd`=5, opcode 7'h13, `exe_forwarding_a_option`=01, `ex_is_flushed`=0.
- Load-use: lw x5 in EXE, `flush_exe_reg`=1 for one cycle -> one bubble (`exe_has_rd`=0) and `perf_bubble_cnt`=1. The dependent instruction loads on the following cycle.
- Hold priority: `hold`=1 together with `flush_exe_reg`=1 and `redirect_flush`=1 for 3 cycles -> `exe_*` unchanged, `perf_hold_cnt`=3, bubble and redirect counters unchanged.
- Redirect plus load-use in the same cycle -> single bubble, `perf_redirect_cnt`=1, `perf_bubble_cnt`=0.
- Saturation (counter preset by force to all-ones), `hold`=1 -> `perf_hold_cnt` stays 32'hFFFF_FFFF. With the macro undefined, all `perf_*` read 0 throughout.
